// File: rtl/debug_command_control.sv
// UART debug command sequencer: program load, run/step gating of the
// pipeline clock enable, and state-dump handshake.
module debug_command_control #(
  parameter int NBITS = 32,
  parameter int IM_ADDR_LENGTH = 10,
  parameter int IM_MEM_SIZE = 1024,
  parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_done,
  input  logic                      halt_detected,
  input  logic                      send_done,
  output logic                      im_wr_en,
  output logic [IM_ADDR_LENGTH-1:0] im_wr_addr,
  output logic [NBITS-1:0]          im_wr_data,
  output logic                      cpu_enable,
  output logic                      cpu_clear,
  output logic                      send_flag,
  output logic                      busy
);

  localparam int NBYTES = NBITS / 8;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [IM_ADDR_LENGTH-1:0] LAST_ADDR =
    IM_ADDR_LENGTH'(IM_MEM_SIZE - 1);

  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_E = 8'h45;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    LOAD_WR,
    LOAD_END,
    RUN,
    STEP_WAIT,
    STEP_EXEC,
    SEND_START,
    SEND_WAIT
  } state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [IM_ADDR_LENGTH-1:0] addr;
  logic [NBITS-1:0]          shift;
  logic                      ret_step;
  logic                      rx;
  logic [NBITS-1:0]          word_next;

  // A byte arriving together with send_done is dropped.
  assign rx = rx_done & ~send_done;
  assign word_next = {shift[NBITS-9:0], rx_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      shift      <= '0;
      ret_step   <= 1'b0;
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
      cpu_enable <= 1'b0;
      cpu_clear  <= 1'b0;
      send_flag  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      im_wr_en  <= 1'b0;
      cpu_clear <= 1'b0;
      send_flag <= 1'b0;
      case (state)
        IDLE: begin
          cpu_enable <= 1'b0;
          if (rx) begin
            if (rx_data == CMD_L) begin
              state <= LOAD;
              addr  <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
            end else if (rx_data == CMD_C) begin
              state      <= RUN;
              cpu_enable <= 1'b1;
              busy       <= 1'b1;
            end else if (rx_data == CMD_S) begin
              state <= STEP_WAIT;
              busy  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (rx) begin
            shift <= word_next;
            if (cnt == LAST_BYTE) begin
              cnt        <= '0;
              state      <= LOAD_WR;
              im_wr_en   <= 1'b1;
              im_wr_addr <= addr;
              im_wr_data <= word_next;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LOAD_WR: begin
          if (shift == HALT_WORD || addr == LAST_ADDR) begin
            state     <= LOAD_END;
            cpu_clear <= 1'b1;
          end else begin
            addr  <= addr + 1'b1;
            state <= LOAD;
          end
        end
        LOAD_END: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        RUN: begin
          if (halt_detected) begin
            cpu_enable <= 1'b0;
            ret_step   <= 1'b0;
            state      <= SEND_START;
          end else begin
            cpu_enable <= 1'b1;
          end
        end
        STEP_WAIT: begin
          cpu_enable <= 1'b0;
          if (rx && rx_data == CMD_S) begin
            ret_step <= 1'b1;
            if (halt_detected) begin
              state <= SEND_START;
            end else begin
              cpu_enable <= 1'b1;
              state      <= STEP_EXEC;
            end
          end else if (rx && rx_data == CMD_E) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        STEP_EXEC: begin
          cpu_enable <= 1'b0;
          ret_step   <= 1'b1;
          state      <= SEND_START;
        end
        SEND_START: begin
          cpu_enable <= 1'b0;
          send_flag  <= 1'b1;
          state      <= SEND_WAIT;
        end
        SEND_WAIT: begin
          cpu_enable <= 1'b0;
          if (send_done) begin
            state <= ret_step ? STEP_WAIT : IDLE;
            busy  <= ret_step;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          im_wr_en   <= 1'b0;
          im_wr_addr <= '0;
          im_wr_data <= '0;
          cpu_enable <= 1'b0;
          cpu_clear  <= 1'b0;
          send_flag  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_command_control.sv
// Randomized bench for debug_command_control with a transaction-level
// model of loads, run/step enables and dump handshakes.
module tb_debug_command_control;

  localparam int NB = 32;
  localparam int AW = 10;
  localparam int MS = 4;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_E = 8'h45;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          halt_detected;
  logic          send_done;
  logic          im_wr_en;
  logic [AW-1:0] im_wr_addr;
  logic [NB-1:0] im_wr_data;
  logic          cpu_enable;
  logic          cpu_clear;
  logic          send_flag;
  logic          busy;

  always #5 clk = ~clk;

  debug_command_control #(
    .NBITS(NB),
    .IM_ADDR_LENGTH(AW),
    .IM_MEM_SIZE(MS),
    .HALT_WORD(HALT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .halt_detected(halt_detected),
    .send_done(send_done),
    .im_wr_en(im_wr_en),
    .im_wr_addr(im_wr_addr),
    .im_wr_data(im_wr_data),
    .cpu_enable(cpu_enable),
    .cpu_clear(cpu_clear),
    .send_flag(send_flag),
    .busy(busy)
  );

  int passed = 0;
  int total = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Observed transactions
  logic [41:0] wr_q[$];
  int clr_cnt = 0;
  int en_cnt = 0;
  int en_rise = 0;
  int flag_cnt = 0;
  logic en_d = 1'b0;

  always @(negedge clk) begin
    if (im_wr_en) wr_q.push_back({im_wr_addr, im_wr_data});
    if (cpu_clear) clr_cnt++;
    if (cpu_enable) en_cnt++;
    if (cpu_enable && !en_d) en_rise++;
    if (send_flag) flag_cnt++;
    en_d = cpu_enable;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic done_pulse();
    send_done = 1'b1;
    tick();
    send_done = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    do b = 8'($urandom);
    while (b == CMD_L || b == CMD_C || b == CMD_S || b == CMD_E);
    return b;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
    while (w == HALT);
    return w;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({im_wr_en, im_wr_addr, im_wr_data,
                cpu_enable, cpu_clear, send_flag, busy});
  endfunction

  logic [31:0] prog[$];

  task automatic run_load();
    logic [41:0] exp[$];
    int base;
    int c0;
    bit ended;
    bit active;
    logic [31:0] w;
    base = wr_q.size();
    c0 = clr_cnt;
    ended = 0;
    for (int i = 0; i < prog.size(); i++) begin
      if (!ended) begin
        exp.push_back({10'(i), prog[i]});
        if (prog[i] == HALT || i == MS - 1) ended = 1;
      end
    end
    send(CMD_L);
    idle(2);
    active = 1;
    for (int i = 0; i < prog.size(); i++) begin
      w = prog[i];
      for (int b = 0; b < 4; b++) begin
        send(w[31-8*b -: 8]);
        if (b == 3) check("wr_latency", 64'(im_wr_en), 64'(active));
        idle(2);
      end
      if (active && (w == HALT || i == MS - 1)) active = 0;
    end
    idle(4);
    check("wr_count", 64'(wr_q.size() - base), 64'(exp.size()));
    for (int i = 0; i < exp.size() && base + i < wr_q.size(); i++)
      check("wr_entry", 64'(wr_q[base+i]), 64'(exp[i]));
    check("clear_pulses", 64'(clr_cnt - c0), 64'd1);
    check("load_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int hp;
    int k;
    int e0;
    int r0;
    int f0;
    int w0;
    reset = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    halt_detected = 1'b0;
    send_done = 1'b0;
    idle(2);
    check("reset_outputs", outs(), 64'd0);
    reset = 1'b0;
    idle(1);

    // Directed load with trailing word after HALT
    prog = '{32'h20080005, HALT, 32'h11223344};
    run_load();

    // Overflow: five non-halt words into a 4-word memory
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(rand_word());
    run_load();

    // Random programs
    for (int it = 0; it < 6; it++) begin
      prog.delete();
      n = $urandom_range(1, 6);
      hp = $urandom_range(0, n);
      if (hp == n && n < MS) hp = n - 1;
      for (int i = 0; i < n; i++) prog.push_back(i == hp ? HALT : rand_word());
      run_load();
    end

    // Continuous runs; last one has rx_done colliding with send_done
    for (int it = 0; it < 5; it++) begin
      e0 = en_cnt;
      f0 = flag_cnt;
      n = $urandom_range(1, 20);
      send(CMD_C);
      check("run_busy", 64'(busy), 64'd1);
      for (int i = 0; i < n - 1; i++) begin
        if (i == 0) begin
          rx_data = CMD_L;
          rx_done = 1'b1;
        end
        tick();
        rx_done = 1'b0;
      end
      halt_detected = 1'b1;
      tick();
      check("halt_en_off", 64'(cpu_enable), 64'd0);
      check("halt_flag_early", 64'(send_flag), 64'd0);
      tick();
      check("halt_flag", 64'(send_flag), 64'd1);
      idle($urandom_range(0, 3));
      check("dump_busy", 64'(busy), 64'd1);
      if (it == 4) begin
        rx_data = CMD_L;
        rx_done = 1'b1;
        send_done = 1'b1;
        tick();
        rx_done = 1'b0;
        send_done = 1'b0;
      end else begin
        done_pulse();
      end
      check("run_done_idle", 64'(busy), 64'd0);
      halt_detected = 1'b0;
      idle(2);
      check("run_still_idle", 64'(busy), 64'd0);
      check("run_en_cycles", 64'(en_cnt - e0), 64'(n));
      check("run_flags", 64'(flag_cnt - f0), 64'd1);
    end

    // Step mode
    for (int it = 0; it < 3; it++) begin
      e0 = en_cnt;
      r0 = en_rise;
      f0 = flag_cnt;
      k = $urandom_range(1, 4);
      send(CMD_S);
      check("step_enter_busy", 64'(busy), 64'd1);
      check("step_enter_en", 64'(cpu_enable), 64'd0);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          send(CMD_C);
          idle(2);
          check("step_c_busy", 64'(busy), 64'd1);
          check("step_c_en", 64'(cpu_enable), 64'd0);
        end
        send(CMD_S);
        check("step_en_on", 64'(cpu_enable), 64'd1);
        tick();
        check("step_en_off", 64'(cpu_enable), 64'd0);
        tick();
        check("step_flag", 64'(send_flag), 64'd1);
        idle($urandom_range(0, 3));
        done_pulse();
        check("step_return", 64'(busy), 64'd1);
        idle(1);
      end
      if (it == 2) begin
        halt_detected = 1'b1;
        send(CMD_S);
        check("halt_step_en", 64'(cpu_enable), 64'd0);
        tick();
        check("halt_step_flag", 64'(send_flag), 64'd1);
        done_pulse();
        halt_detected = 1'b0;
        check("halt_step_return", 64'(busy), 64'd1);
        idle(1);
      end
      send(CMD_E);
      check("step_exit", 64'(busy), 64'd0);
      check("step_en_cycles", 64'(en_cnt - e0), 64'(k));
      check("step_en_pulses", 64'(en_rise - r0), 64'(k));
      check("step_flags", 64'(flag_cnt - f0), 64'(it == 2 ? k + 1 : k));
    end

    // Reset during third load byte
    w0 = wr_q.size();
    send(CMD_L);
    idle(2);
    send(rand_byte());
    idle(2);
    send(rand_byte());
    idle(2);
    rx_data = rand_byte();
    rx_done = 1'b1;
    reset = 1'b1;
    tick();
    rx_done = 1'b0;
    reset = 1'b0;
    check("rst_load_outputs", outs(), 64'd0);
    send(rand_byte());
    idle(3);
    check("rst_load_nowrite", 64'(wr_q.size() - w0), 64'd0);
    check("rst_load_idle", 64'(busy), 64'd0);

    // Reset while running
    send(CMD_C);
    idle(3);
    check("pre_rst_en", 64'(cpu_enable), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_run_outputs", outs(), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
